chart_sequencer: RTL and testbench

- Plays back one song chart, one column per beat, for the downstream note-scroll/hit-judge logic.
- Drives song_select into the combinational song loader and latches the returned 100-bit red/blue/yellow lane vectors and total_notes. Then it emits one 3-lane column per beat tick, MSB (bit CHART_LEN-1) first.
- Tracks beat position and emitted-note count, and flags when the emitted-note count disagrees with the chart's total_notes.

---
 rtl/chart_sequencer.sv | 177 +++++++++++++++++
 tb/tb_chart_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Beat-synchronous song-chart player: latches three lane vectors from the song loader and emits one column per beat.
// Optional CHART_SEQUENCER_LOOP_EN: replay the current chart forever instead of stopping in DONE.
module chart_sequencer #(
  parameter int CHART_LEN      = 100,
  parameter int TICKS_PER_BEAT = 12500000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pause,
  input  logic [4:0]           song_req,
  output logic [4:0]           song_select,
  input  logic [CHART_LEN-1:0] chart_red,
  input  logic [CHART_LEN-1:0] chart_blue,
  input  logic [CHART_LEN-1:0] chart_yellow,
  input  logic [7:0]           chart_total,
  output logic                 note_red,
  output logic                 note_blue,
  output logic                 note_yellow,
  output logic                 beat_strobe,
  output logic [6:0]           beat_index,
  output logic [7:0]           notes_emitted,
  output logic                 busy,
  output logic                 done,
  output logic                 chart_error
);

  localparam int                DIV_W    = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICKS_PER_BEAT - 1);
  localparam int                CNT_W    = $clog2(CHART_LEN + 1);
  localparam logic [CNT_W-1:0]  COLS_ALL = CNT_W'(CHART_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t               state, state_next;
  logic [DIV_W-1:0]     div;
  logic [CNT_W-1:0]     cols_out;
  logic [CHART_LEN-1:0] red_sr, blue_sr, yellow_sr;
  logic [7:0]           total_q;
  logic                 tick, terminal, chart_end;
  logic [1:0]           col_pop;
  logic [8:0]           notes_sum;

  // A terminal count in PLAY still fires while pause is high; the resume cycle itself counts.
  assign tick      = ((state == S_PLAY) && (!pause || (div == DIV_LAST))) ||
                     ((state == S_PAUSED) && !pause);
  assign terminal  = tick && (div == DIV_LAST);
  assign chart_end = terminal && (cols_out == COLS_ALL);
  assign col_pop   = {1'b0, red_sr[CHART_LEN-1]} + {1'b0, blue_sr[CHART_LEN-1]} +
                     {1'b0, yellow_sr[CHART_LEN-1]};
  assign notes_sum = {1'b0, notes_emitted} + {7'd0, col_pop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = S_LOAD;
        S_LOAD:   state_next = S_PLAY;
        S_PLAY, S_PAUSED: begin
          if (chart_end) begin
`ifdef CHART_SEQUENCER_LOOP_EN
            state_next = S_LOAD;
`else
            state_next = S_DONE;
`endif
          end else if (pause) begin
            state_next = S_PAUSED;
          end else begin
            state_next = S_PLAY;
          end
        end
        S_DONE:   if (start) state_next = S_LOAD;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      song_select   <= '0;
      red_sr        <= '0;
      blue_sr       <= '0;
      yellow_sr     <= '0;
      total_q       <= '0;
      div           <= '0;
      cols_out      <= '0;
      note_red      <= 1'b0;
      note_blue     <= 1'b0;
      note_yellow   <= 1'b0;
      beat_strobe   <= 1'b0;
      beat_index    <= '0;
      notes_emitted <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      chart_error   <= 1'b0;
    end else begin
      beat_strobe <= 1'b0;
      busy        <= (state_next == S_LOAD) || (state_next == S_PLAY) || (state_next == S_PAUSED);
      done        <= (state_next == S_DONE);
      if (abort) begin
        note_red      <= 1'b0;
        note_blue     <= 1'b0;
        note_yellow   <= 1'b0;
        beat_index    <= '0;
        notes_emitted <= '0;
        chart_error   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              song_select <= song_req;
              chart_error <= 1'b0;
            end
          end
          S_LOAD: begin
            red_sr        <= chart_red;
            blue_sr       <= chart_blue;
            yellow_sr     <= chart_yellow;
            total_q       <= chart_total;
            div           <= '0;
            cols_out      <= '0;
            beat_index    <= '0;
            notes_emitted <= '0;
          end
          S_PLAY, S_PAUSED: begin
            if (terminal) begin
              div <= '0;
              if (chart_end) begin
                note_red    <= 1'b0;
                note_blue   <= 1'b0;
                note_yellow <= 1'b0;
`ifdef CHART_SEQUENCER_LOOP_EN
                chart_error <= chart_error | (notes_emitted != total_q);
`else
                chart_error <= (notes_emitted != total_q);
`endif
              end else begin
                note_red    <= red_sr[CHART_LEN-1];
                note_blue   <= blue_sr[CHART_LEN-1];
                note_yellow <= yellow_sr[CHART_LEN-1];
                red_sr      <= {red_sr[CHART_LEN-2:0], 1'b0};
                blue_sr     <= {blue_sr[CHART_LEN-2:0], 1'b0};
                yellow_sr   <= {yellow_sr[CHART_LEN-2:0], 1'b0};
                beat_strobe <= 1'b1;
                cols_out    <= cols_out + 1'b1;
                // Column 0 keeps index 0; later strobes advance it.
                if (cols_out != '0) beat_index <= beat_index + 7'd1;
                notes_emitted <= notes_sum[8] ? 8'hFF : notes_sum[7:0];
              end
            end else if (tick) begin
              div <= div + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer with a 4-cycle beat; expectations are hand-derived cycle counts and note sums.
// Build with CHART_SEQUENCER_LOOP_EN defined to exercise the looping variant.
module tb_chart_sequencer;
  localparam int CL  = 100;
  localparam int TPB = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pause = 1'b0;
  logic [4:0]    song_req = '0;
  logic [4:0]    song_select;
  logic [CL-1:0] chart_red = '0;
  logic [CL-1:0] chart_blue = '0;
  logic [CL-1:0] chart_yellow = '0;
  logic [7:0]    chart_total = '0;
  logic          note_red, note_blue, note_yellow, beat_strobe;
  logic [6:0]    beat_index;
  logic [7:0]    notes_emitted;
  logic          busy, done, chart_error;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  chart_sequencer #(.CHART_LEN(CL), .TICKS_PER_BEAT(TPB)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .pause(pause),
    .song_req(song_req), .song_select(song_select),
    .chart_red(chart_red), .chart_blue(chart_blue), .chart_yellow(chart_yellow),
    .chart_total(chart_total),
    .note_red(note_red), .note_blue(note_blue), .note_yellow(note_yellow),
    .beat_strobe(beat_strobe), .beat_index(beat_index), .notes_emitted(notes_emitted),
    .busy(busy), .done(done), .chart_error(chart_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!beat_strobe && n < limit);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < limit);
  endtask

  task automatic pulse_start(input logic [4:0] song);
    song_req = song;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    check_cnt++; if ({busy, done, chart_error, beat_strobe} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, chart_error, beat_strobe}); else pass_cnt++;
    check_cnt++; if ({note_red, note_blue, note_yellow} !== 3'b000) $display("FAIL reset_notes: got %b want 000", {note_red, note_blue, note_yellow}); else pass_cnt++;
    check_cnt++; if (song_select !== 5'd0) $display("FAIL reset_song_select: got %0d want 0", song_select); else pass_cnt++;
    resetn = 1'b1;
    tick();
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else pass_cnt++;
    $display("test_reset done: busy=%b done=%b", busy, done);
  endtask

  task automatic test_basic();
    int n;
    int strobes;
    chart_red = '0; chart_red[99] = 1'b1; chart_red[0] = 1'b1;
    chart_yellow = '0; chart_yellow[98] = 1'b1;
    chart_blue = '0;
    chart_total = 8'd3;
    pulse_start(5'd15);
    check_cnt++; if (song_select !== 5'd15) $display("FAIL basic_song_select: got %0d want 15", song_select); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_load: got %b want 1", busy); else pass_cnt++;
    wait_strobe(20, n);
    check_cnt++; if (n !== 5) $display("FAIL basic_first_latency: got %0d want 5", n); else pass_cnt++;
    check_cnt++; if ({note_red, note_blue, note_yellow} !== 3'b100) $display("FAIL basic_col0: got %b want 100", {note_red, note_blue, note_yellow}); else pass_cnt++;
    check_cnt++; if (beat_index !== 7'd0) $display("FAIL basic_idx0: got %0d want 0", beat_index); else pass_cnt++;
    check_cnt++; if (notes_emitted !== 8'd1) $display("FAIL basic_notes0: got %0d want 1", notes_emitted); else pass_cnt++;
    $display("strobe 1: cycles=%0d notes=%b idx=%0d", n, {note_red, note_blue, note_yellow}, beat_index);
    wait_strobe(20, n);
    check_cnt++; if (n !== 4) $display("FAIL basic_beat_gap: got %0d want 4", n); else pass_cnt++;
    check_cnt++; if ({note_red, note_blue, note_yellow} !== 3'b001) $display("FAIL basic_col1: got %b want 001", {note_red, note_blue, note_yellow}); else pass_cnt++;
    check_cnt++; if (beat_index !== 7'd1) $display("FAIL basic_idx1: got %0d want 1", beat_index); else pass_cnt++;
    $display("strobe 2: cycles=%0d notes=%b idx=%0d", n, {note_red, note_blue, note_yellow}, beat_index);
    strobes = 2;
    for (int k = 2; k < CL; k++) begin
      wait_strobe(20, n);
      if (n == 4 && beat_strobe) strobes++;
    end
    check_cnt++; if (strobes !== 100) $display("FAIL basic_strobe_count: got %0d want 100", strobes); else pass_cnt++;
    check_cnt++; if (beat_index !== 7'd99) $display("FAIL basic_idx99: got %0d want 99", beat_index); else pass_cnt++;
    check_cnt++; if (notes_emitted !== 8'd3) $display("FAIL basic_notes_total: got %0d want 3", notes_emitted); else pass_cnt++;
    check_cnt++; if (note_red !== 1'b1) $display("FAIL basic_col99: got %b want 1", note_red); else pass_cnt++;
    $display("strobe 100: idx=%0d notes_emitted=%0d", beat_index, notes_emitted);
`ifdef CHART_SEQUENCER_LOOP_EN
    wait_strobe(20, n);
    check_cnt++; if (n !== 9) $display("FAIL loop_restart_gap: got %0d want 9", n); else pass_cnt++;
    check_cnt++; if (beat_index !== 7'd0) $display("FAIL loop_idx: got %0d want 0", beat_index); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL loop_done: got %b want 0", done); else pass_cnt++;
    check_cnt++; if (notes_emitted !== 8'd1) $display("FAIL loop_notes: got %0d want 1", notes_emitted); else pass_cnt++;
    $display("loop restart: cycles=%0d idx=%0d done=%b", n, beat_index, done);
`else
    wait_done(20, n);
    check_cnt++; if (n !== 4) $display("FAIL basic_done_latency: got %0d want 4", n); else pass_cnt++;
    check_cnt++; if (chart_error !== 1'b0) $display("FAIL basic_chart_error: got %b want 0", chart_error); else pass_cnt++;
    check_cnt++; if ({busy, beat_strobe, note_red} !== 3'b000) $display("FAIL basic_done_outputs: got %b want 000", {busy, beat_strobe, note_red}); else pass_cnt++;
    $display("done: cycles=%0d done=%b chart_error=%b", n, done, chart_error);
`endif
  endtask

  task automatic test_mismatch();
    int n;
    chart_total = 8'd4;
`ifdef CHART_SEQUENCER_LOOP_EN
    pulse_abort();
    pulse_start(5'd15);
    n = 0;
    do begin
      tick();
      n++;
    end while (!chart_error && n < 1000);
    check_cnt++; if (n !== 405) $display("FAIL mismatch_error_latency: got %0d want 405", n); else pass_cnt++;
    tick();
    tick();
    check_cnt++; if ({chart_error, done} !== 2'b10) $display("FAIL mismatch_sticky: got %b want 10", {chart_error, done}); else pass_cnt++;
    $display("mismatch loop: cycles=%0d chart_error=%b", n, chart_error);
`else
    pulse_start(5'd15);
    check_cnt++; if ({done, busy} !== 2'b01) $display("FAIL mismatch_restart: got %b want 01", {done, busy}); else pass_cnt++;
    wait_done(1000, n);
    check_cnt++; if (n !== 405) $display("FAIL mismatch_done_latency: got %0d want 405", n); else pass_cnt++;
    check_cnt++; if (chart_error !== 1'b1) $display("FAIL mismatch_chart_error: got %b want 1", chart_error); else pass_cnt++;
    $display("mismatch: cycles=%0d done=%b chart_error=%b", n, done, chart_error);
`endif
  endtask

  task automatic test_pause();
    int n;
    int sc;
    pulse_abort();
    chart_total = 8'd3;
    pulse_start(5'd15);
    wait_strobe(20, n);
    wait_strobe(20, n);
    check_cnt++; if (beat_index !== 7'd1) $display("FAIL pause_pre_idx: got %0d want 1", beat_index); else pass_cnt++;
    tick();
    tick();
    pause = 1'b1;
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (beat_strobe) sc++;
    end
    pause = 1'b0;
    check_cnt++; if (sc !== 0) $display("FAIL pause_strobes: got %0d want 0", sc); else pass_cnt++;
    check_cnt++; if ({busy, beat_index} !== {1'b1, 7'd1}) $display("FAIL pause_hold: got busy=%b idx=%0d want busy=1 idx=1", busy, beat_index); else pass_cnt++;
    wait_strobe(20, n);
    check_cnt++; if (n !== 2) $display("FAIL pause_resume_latency: got %0d want 2", n); else pass_cnt++;
    check_cnt++; if (beat_index !== 7'd2) $display("FAIL pause_post_idx: got %0d want 2", beat_index); else pass_cnt++;
    $display("pause: resume cycles=%0d idx=%0d", n, beat_index);
  endtask

  task automatic test_abort_vs_start();
    check_cnt++; if (notes_emitted !== 8'd2) $display("FAIL abort_pre_notes: got %0d want 2", notes_emitted); else pass_cnt++;
    abort = 1'b1;
    start = 1'b1;
    song_req = 5'd3;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_cnt++; if ({busy, notes_emitted, beat_index} !== {1'b0, 8'd0, 7'd0}) $display("FAIL abort_clear: got busy=%b notes=%0d idx=%0d want 0 0 0", busy, notes_emitted, beat_index); else pass_cnt++;
    check_cnt++; if (song_select !== 5'd15) $display("FAIL abort_song_select: got %0d want 15", song_select); else pass_cnt++;
    tick();
    check_cnt++; if (busy !== 1'b0) $display("FAIL abort_no_load: got %b want 0", busy); else pass_cnt++;
    $display("abort: busy=%b notes=%0d song_select=%0d", busy, notes_emitted, song_select);
  endtask

  task automatic test_reset_mid_play();
    int n;
    int sc;
    pulse_start(5'd7);
    wait_strobe(20, n);
    wait_strobe(20, n);
    check_cnt++; if (note_yellow !== 1'b1) $display("FAIL rst_pre_yellow: got %b want 1", note_yellow); else pass_cnt++;
    #2;
    resetn = 1'b0;
    #1;
    check_cnt++; if ({note_yellow, busy, beat_index, notes_emitted} !== 17'd0) $display("FAIL rst_async_clear: got yellow=%b busy=%b idx=%0d notes=%0d want all 0", note_yellow, busy, beat_index, notes_emitted); else pass_cnt++;
    check_cnt++; if (song_select !== 5'd0) $display("FAIL rst_async_song: got %0d want 0", song_select); else pass_cnt++;
    tick();
    tick();
    resetn = 1'b1;
    sc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (beat_strobe || busy) sc++;
    end
    check_cnt++; if (sc !== 0) $display("FAIL rst_idle_after: got %0d active cycles want 0", sc); else pass_cnt++;
    $display("reset mid-play: busy=%b done=%b", busy, done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_pause();
    test_abort_vs_start();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
